// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard deframer producing toggled 11-bit key event words
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
    logic          dat_a_q, dat_a_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fclk_q, fclk_d, fclk_p_q, fclk_p_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_vld_q, byte_vld_d, bad_q, bad_d, start_bad_q, start_bad_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          strobe_q, strobe_d, err_q, err_d;
    logic          fall, tmo_hit;

    assign fall       = fclk_p_q & ~fclk_q;
    assign tmo_hit    = (state_q == RECV) && !fall && (tmo_cnt_q == TW'(TIMEOUT));
    assign ps2_key    = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = err_q;

    // synchronizers, glitch filter on the clock, and one-cycle data delay to line up with fclk
    always_comb begin
        clk_s_d   = {clk_s_q[0], ps2_clk};
        dat_s_d   = {dat_s_q[0], ps2_data};
        dat_a_d   = dat_s_q[1];
        flt_cnt_d = (clk_s_q[1] == fclk_q || flt_cnt_q == FW'(FILTER_LEN - 1)) ? '0 : flt_cnt_q + 1'b1;
        fclk_d    = (clk_s_q[1] != fclk_q && flt_cnt_q == FW'(FILTER_LEN - 1)) ? clk_s_q[1] : fclk_q;
        fclk_p_d  = fclk_q;
    end

    // frame state register
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // frame next state: start bit enters RECV, stop bit or timeout returns to IDLE
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)                  state_d = (fall && !dat_a_q) ? RECV : IDLE;
        else if (fall && bit_cnt_q == 4'd9)   state_d = IDLE;
        else if (tmo_hit)                     state_d = IDLE;
    end

    // frame outputs: bit shifting, parity/stop capture and frame verdict
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        par_d       = par_q;
        tmo_cnt_d   = (state_q == RECV && !fall && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
        byte_vld_d  = 1'b0;
        bad_d       = 1'b0;
        start_bad_d = 1'b0;
        if (fall && state_q == IDLE) begin
            bit_cnt_d   = 4'd0;
            start_bad_d = dat_a_q;
        end else if (fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8)       sr_d  = {dat_a_q, sr_q[7:1]};
            else if (bit_cnt_q == 4'd8) par_d = dat_a_q;
            else begin
                byte_vld_d = (^{sr_q, par_q}) & dat_a_q;
                bad_d      = ~((^{sr_q, par_q}) & dat_a_q);
            end
        end
    end

    // byte decoder: prefix tracking, Pause swallowing and event publication
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        err_d    = bad_q | start_bad_q | tmo_hit;
        if (bad_q || tmo_hit) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = 3'd0;
        end else if (byte_vld_q) begin
            if (skip_q != 3'd0)      skip_d = skip_q - 3'd1;
            else if (sr_q == 8'hE0)  ext_d  = 1'b1;
            else if (sr_q == 8'hF0)  brk_d  = 1'b1;
            else if (sr_q == 8'hE1) begin
                skip_d = 3'd7;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end else if (ext_q || brk_q || !(sr_q inside {8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hAA})) begin
                key_d    = {~key_q[10], ~brk_q, ext_q, sr_q};
                strobe_d = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    // datapath registers; idle-high lines reset to 1 so no spurious edge follows reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s_q     <= 2'b11;
            dat_s_q     <= 2'b11;
            dat_a_q     <= 1'b1;
            flt_cnt_q   <= '0;
            fclk_q      <= 1'b1;
            fclk_p_q    <= 1'b1;
            bit_cnt_q   <= 4'd0;
            sr_q        <= 8'd0;
            par_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_vld_q  <= 1'b0;
            bad_q       <= 1'b0;
            start_bad_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= 3'd0;
            key_q       <= 11'd0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_s_q     <= clk_s_d;
            dat_s_q     <= dat_s_d;
            dat_a_q     <= dat_a_d;
            flt_cnt_q   <= flt_cnt_d;
            fclk_q      <= fclk_d;
            fclk_p_q    <= fclk_p_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            par_q       <= par_d;
            tmo_cnt_q   <= tmo_cnt_d;
            byte_vld_q  <= byte_vld_d;
            bad_q       <= bad_d;
            start_bad_q <= start_bad_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and randomized PS/2 frames checked against a byte-level model
module tb_ps2_key_decoder;
    localparam int FL   = 8;
    localparam int TMO  = 400;
    localparam int HALF = 30;

    logic        clk_sys = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        key_strobe, frame_err;

    int checks = 0, errors = 0;
    int cyc = 0, n_stb = 0, n_err = 0, n_both = 0, stb_cyc = 0, stop_cyc = 0;
    logic [10:0] m_key = 11'd0;
    bit          m_ext = 1'b0, m_brk = 1'b0;
    int          m_skip = 0, m_stb = 0, m_err = 0;
    logic [7:0]  pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hFA, 8'h1C, 8'h75, 8'h14, 8'h77, 8'h5A, 8'hFF};

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_key(ps2_key), .key_strobe(key_strobe), .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (key_strobe) begin
            n_stb   <= n_stb + 1;
            stb_cyc <= cyc;
        end
        if (frame_err) n_err <= n_err + 1;
        if (key_strobe && frame_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk  = 1'b0;
            stop_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
            if (glitch) begin
                tick(12);
                ps2_clk = 1'b0;
                tick(FL - 1);
                ps2_clk = 1'b1;
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) begin
            m_skip = 7;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end else if (m_ext || m_brk || !(b inside {8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hAA})) begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_stb++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic mdl_err();
        m_err++;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad, input bit glitch);
        send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11, glitch);
        tick(FL + 10);
        if (bad) mdl_err();
        else mdl_byte(b);
    endtask

    task automatic compare(input string tag);
        check({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        check({tag, "_strobes"}, n_stb, m_stb);
        check({tag, "_errs"}, n_err, m_err);
    endtask

    initial begin
        tick(5);
        reset = 1'b0;
        tick(5);
        check("rst_key", 32'(ps2_key), 0);
        check("rst_strobe", 32'(key_strobe), 0);
        check("rst_err", 32'(frame_err), 0);

        frame(8'h1C, 0, 0);
        check("make_1c", 32'(ps2_key), 32'h61C);
        check("latency", stb_cyc - stop_cyc, FL + 4);
        compare("make_1c");

        frame(8'hF0, 0, 0); frame(8'h1C, 0, 0);
        check("break_1c", 32'(ps2_key), 32'h01C);
        frame(8'hE0, 0, 0); frame(8'h75, 0, 0);
        check("ext_make", 32'(ps2_key), 32'h775);
        frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0);
        check("ext_break", 32'(ps2_key), 32'h175);
        compare("seq");

        frame(8'h1C, 1, 0);
        check("par_key", 32'(ps2_key), 32'h175);
        compare("parity");
        frame(8'h1C, 0, 0);
        check("after_par", 32'(ps2_key), 32'h61C);

        frame(8'hE0, 0, 0);
        send_bits({1'b1, 1'b0, 8'h75, 1'b0}, 5, 0);
        tick(TMO + 200);
        mdl_err();
        compare("timeout");
        frame(8'h75, 0, 0);
        check("tmo_ext", 32'(ps2_key[8]), 0);
        compare("after_tmo");

        frame(8'h1C, 0, 1);
        compare("glitch");
        foreach (pool[i]) if (i < 0) ;
        frame(8'hE1, 0, 0); frame(8'h14, 0, 0); frame(8'h77, 0, 0); frame(8'hE1, 0, 0);
        frame(8'hF0, 0, 0); frame(8'h14, 0, 0); frame(8'hF0, 0, 0); frame(8'h77, 0, 0);
        compare("pause");

        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_key", 32'(ps2_key), 0);
        check("mid_rst_strobe", 32'(key_strobe), 0);
        check("mid_rst_err", 32'(frame_err), 0);
        tick(TMO + 100);
        m_key = 11'd0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
        compare("mid_rst");
        frame(8'h1C, 0, 0);
        check("post_rst", 32'(ps2_key), 32'h61C);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 15) < 12) ? pool[$urandom_range(0, 11)] : 8'($urandom);
            frame(b, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
            compare("rand");
        end

        check("no_overlap", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
